// File: rtl/instruction_fetch_unit.sv
// PC/fetch sequencer in front of a combinational instruction RAM: resolves JUMP/BZ/PREBR/HLT/IN flow.
// Zero-cycle address-to-instrValid latency; stall freezes all state and masks instrValid/inputReq.
module instruction_fetch_unit #(
   parameter int              ADDR_WIDTH = 10,
   parameter int              DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter logic [5:0]      OP_JUMP    = 6'd21,
   parameter logic [5:0]      OP_BZ      = 6'd19,
   parameter logic [5:0]      OP_PREBR   = 6'd31,
   parameter logic [5:0]      OP_HLT     = 6'd28,
   parameter logic [5:0]      OP_IN      = 6'd29
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] iRAMOutput,
   input  logic [31:0]           branchValue,
   input  logic                  inputValid,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instrValid,
   output logic                  inputReq,
   output logic                  halted,
   output logic [15:0]           retiredCount
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_WAIT_IN = 2'd1,
      S_HALTED  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  zflag_q, zflag_d;
   logic [15:0]           count_q, count_d;

   logic [5:0]            op;
   logic [ADDR_WIDTH-1:0] imm_addr;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  instr_vld;
   logic                  input_req;
   logic                  unused_bits;

   assign op          = iRAMOutput[31:26];
   assign imm_addr    = iRAMOutput[ADDR_WIDTH-1:0];
   assign pc_inc      = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   assign unused_bits = ^iRAMOutput[25:ADDR_WIDTH];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      zflag_d   = zflag_q;
      instr_vld = 1'b0;
      input_req = 1'b0;
      case (state_q)
         S_RUN: begin
            if (!stall) begin
               instr_vld = 1'b1;
               if (op == OP_JUMP) begin
                  pc_d = imm_addr;
               end else if (op == OP_BZ) begin
                  pc_d = zflag_q ? imm_addr : pc_inc;
               end else if (op == OP_PREBR) begin
                  zflag_d = (branchValue == 32'd0);
                  pc_d    = pc_inc;
               end else if (op == OP_HLT) begin
                  state_d = S_HALTED;
               end else if (op == OP_IN) begin
                  input_req = 1'b1;
                  if (inputValid) begin
                     pc_d = pc_inc;
                  end else begin
                     instr_vld = 1'b0;
                     state_d   = S_WAIT_IN;
                  end
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         S_WAIT_IN: begin
            if (!stall) begin
               input_req = 1'b1;
               instr_vld = inputValid;
               if (inputValid) begin
                  pc_d    = pc_inc;
                  state_d = S_RUN;
               end
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // Counter saturates so long-running programs never appear to restart at zero.
   always_comb begin
      count_d = count_q;
      if (instr_vld && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         zflag_q <= 1'b0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         zflag_q <= zflag_d;
         count_q <= count_d;
      end
   end

   assign address      = pc_q;
   assign instruction  = iRAMOutput;
   assign instrValid   = instr_vld;
   assign inputReq     = input_req;
   assign halted       = (state_q == S_HALTED);
   assign retiredCount = count_q;

endmodule
